z_packer: RTL

Serializer-to-word collector on the result side of the z-producing classifier. It consumes one-bit results over the dav_/rfd handshake, acting as the consumer. It packs every 8 consecutive results into a byte and presents the byte, plus its count of ones, to a downstream consumer over a second dav_/rfd handshake, acting as the producer. While a full byte is waiting for the downstream consumer, upstream results are held off.

---
 rtl/z_packer.sv | 101 ++++++++++
 1 files changed

// File: rtl/z_packer.sv
// rtl/z_packer.sv - packs eight one-bit results into a byte plus ones count, dav_/rfd handshake on both sides
module z_packer (
    input  logic       clock,
    input  logic       reset_,
    input  logic       dav_z_,
    input  logic       z,
    output logic       rfd_z,
    output logic       dav_,
    input  logic       rfd,
    output logic [7:0] out,
    output logic [3:0] n
);

    typedef enum logic [1:0] {
        IN_WAIT  = 2'd0,
        IN_ACK   = 2'd1,
        OUT_WAIT = 2'd2,
        OUT_ACK  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] word;
    logic [3:0] cnt;
    logic [3:0] ones;
    logic       capture;
    logic       emit;
    logic       drain;

    // Handshake outputs are pure state decodes, so the async reset drives them to idle at once.
    assign rfd_z = (state == IN_WAIT);
    assign dav_  = (state != OUT_ACK);

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state <= IN_WAIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        emit       = 1'b0;
        drain      = 1'b0;
        case (state)
            IN_WAIT: begin
                if (!dav_z_) begin
                    capture    = 1'b1;
                    state_next = IN_ACK;
                end
            end
            IN_ACK: begin
                if (dav_z_) begin
                    state_next = (cnt == 4'd8) ? OUT_WAIT : IN_WAIT;
                end
            end
            OUT_WAIT: begin
                if (rfd) begin
                    emit       = 1'b1;
                    state_next = OUT_ACK;
                end
            end
            OUT_ACK: begin
                if (!rfd) begin
                    drain      = 1'b1;
                    state_next = IN_WAIT;
                end
            end
            default: state_next = IN_WAIT;
        endcase
    end

    // cnt stays below 8 while capturing, so its low three bits address the word.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            word <= 8'h00;
            cnt  <= 4'd0;
            ones <= 4'd0;
            out  <= 8'h00;
            n    <= 4'd0;
        end else begin
            if (capture) begin
                word[cnt[2:0]] <= z;
                ones           <= ones + {3'b000, z};
                cnt            <= cnt + 4'd1;
            end
            if (emit) begin
                out <= word;
                n   <= ones;
            end
            if (drain) begin
                word <= 8'h00;
                cnt  <= 4'd0;
                ones <= 4'd0;
            end
        end
    end

endmodule
